// File: rtl/mem_arbiter_if.sv
// Request/return bus between fetch/MEM stages, the arbiter and the memory.
// master = arbiter side, slave = pipeline and memory side.
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_cancel;
  logic        if_gnt;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (
    input  if_req, if_addr, if_cancel,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, if_cancel,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// IF/D arbiter for one single-port fixed-latency memory, one access in flight.
// Optional IF anti-starvation guard: define ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);

  if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_MAX < 1) begin : g_bad_param
    $error("mem_arbiter: illegal parameter value");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [2:0] lat_cnt;
  logic       owner_d;
  logic       owner_wr;
  logic       cancel;

  logic ret;
  logic opp;
  logic pick_d;
  logic issue;
  logic dg;
  logic ig;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
`endif

  always_comb begin
    ret    = (state == BUSY) && (lat_cnt == 3'd1);
    opp    = !rst && ((state == IDLE) || ret);
`ifdef ARB_STARVE_GUARD_EN
    pick_d = bus.d_req &&
             !(bus.if_req && (starve_cnt == SW'(STARVE_MAX)));
`else
    pick_d = bus.d_req;
`endif
    issue  = opp && (bus.if_req || bus.d_req);
    dg     = issue && pick_d;
    ig     = issue && !pick_d;
    bus.d_gnt     = dg;
    bus.if_gnt    = ig;
    bus.mem_en    = issue;
    bus.mem_we    = dg && bus.d_we;
    bus.mem_addr  = dg ? bus.d_addr : (ig ? bus.if_addr : 16'h0);
    bus.mem_wdata = dg ? bus.d_wdata : 16'h0;
    bus.d_rvalid  = !rst && ret && owner_d;
    // a cancel arriving in the return cycle itself still kills it
    bus.if_rvalid = !rst && ret && !owner_d &&
                    !cancel && !bus.if_cancel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_cnt      <= 3'd0;
      owner_d      <= 1'b0;
      owner_wr     <= 1'b0;
      cancel       <= 1'b0;
      bus.if_rdata <= 16'h0;
      bus.d_rdata  <= 16'h0;
    end else begin
      if (bus.if_rvalid)
        bus.if_rdata <= bus.mem_rdata;
      if (ret && owner_d && !owner_wr)
        bus.d_rdata <= bus.mem_rdata;
      if (issue) begin
        state    <= BUSY;
        lat_cnt  <= 3'(MEM_LAT);
        owner_d  <= pick_d;
        owner_wr <= dg && bus.d_we;
        cancel   <= 1'b0;
      end else if (ret) begin
        state   <= IDLE;
        lat_cnt <= 3'd0;
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt - 3'd1;
        if (!owner_d && bus.if_cancel)
          cancel <= 1'b1;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (!bus.if_req || ig)
      starve_cnt <= '0;
    else if (dg && starve_cnt != SW'(STARVE_MAX))
      starve_cnt <= starve_cnt + 1'b1;
  end
`endif

endmodule
